// File: rtl/qdr_pkg.sv
// Shared types and default parameters for the QDR-style burst SRAM.
package qdr_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } burst_state_t;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_ADDR_W    = 3;
    localparam int DEF_BURST_LEN = 2;

    // A single-beat burst still needs a 1-bit counter to keep the port widths legal.
    function automatic int cnt_width(input int burst_len);
        return (burst_len > 1) ? $clog2(burst_len) : 1;
    endfunction

endpackage

// File: rtl/qdr_burst_ctr.sv
// Per-port burst sequencer: IDLE/BURST FSM, beat counter and wrapping address generator.
module qdr_burst_ctr
    import qdr_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd,
    input  logic [ADDR_W-1:0] addr,
    output logic              ready,
    output logic              fire,
    output logic [ADDR_W-1:0] beat_addr,
    output logic [ADDR_W-1:0] ptr
);

    localparam int              CNT_W     = cnt_width(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    burst_state_t      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              accept;

    assign accept = cmd && (state_q == IDLE);

    // NOTE: every flop is updated with <= so all state samples pre-edge values together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    // NOTE: defaults first so no path through the case leaves a target unassigned (no latches).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept && (BURST_LEN > 1)) begin
                    state_d = BURST;
                    cnt_d   = CNT_W'(1);
                end
            end
            BURST: begin
                if (cnt_q == LAST_BEAT) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    // Beat 0 uses the command address directly; later beats follow the registered pointer.
    always_comb begin
        ready     = (state_q == IDLE);
        fire      = accept || (state_q == BURST);
        beat_addr = accept ? addr : ptr_q;
        ptr_d     = fire ? beat_addr + ADDR_W'(1) : ptr_q;
        ptr       = ptr_q;
    end

endmodule

// File: rtl/qdr_burst_sram.sv
// Single-clock burst SRAM with independent write/read ports.
// Define RD_BYPASS_EN to forward same-edge write data on an address collision.
module qdr_burst_sram
    import qdr_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] rd_ptr
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q, rd_data_d, rd_word;
    logic              rd_valid_q, rd_valid_d;
    logic              wr_fire, rd_fire;
    logic [ADDR_W-1:0] wr_beat_addr, rd_beat_addr;

    qdr_burst_ctr #(.ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN)) u_wr_ctr (
        .clk       (clk),
        .rst       (rst),
        .cmd       (wr_cmd),
        .addr      (wr_addr),
        .ready     (wr_ready),
        .fire      (wr_fire),
        .beat_addr (wr_beat_addr),
        .ptr       (wr_ptr)
    );

    qdr_burst_ctr #(.ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN)) u_rd_ctr (
        .clk       (clk),
        .rst       (rst),
        .cmd       (rd_cmd),
        .addr      (rd_addr),
        .ready     (rd_ready),
        .fire      (rd_fire),
        .beat_addr (rd_beat_addr),
        .ptr       (rd_ptr)
    );

    // NOTE: the array has no reset so it maps onto RAM; contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_fire && !rst) begin
            mem_q[wr_beat_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_word = mem_q[rd_beat_addr];
`ifdef RD_BYPASS_EN
        if (wr_fire && (wr_beat_addr == rd_beat_addr)) begin
            rd_word = wr_data;
        end
`endif
        rd_valid_d = rd_fire;
        rd_data_d  = rd_fire ? rd_word : rd_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_qdr_burst_sram.sv
// Self-checking bench for qdr_burst_sram; expected data comes from a word-array model.
module tb_qdr_burst_sram;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 3;
    localparam int BURST_LEN = 2;
    localparam int DEPTH     = 2 ** ADDR_W;

    logic              clk;
    logic              rst;
    logic              wr_cmd;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_cmd;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    logic [DATA_W-1:0] mem_m [DEPTH];
    int                n_vec;
    int                n_err;

    qdr_burst_sram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_cmd   (wr_cmd),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .rd_cmd   (rd_cmd),
        .rd_addr  (rd_addr),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .wr_ptr   (wr_ptr),
        .rd_ptr   (rd_ptr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        n_vec++;
        if (wr_ready !== 1'b1 || rd_ready !== 1'b1 || rd_valid !== 1'b0 ||
            rd_data !== 8'h00 || wr_ptr !== 3'd0 || rd_ptr !== 3'd0) begin
            n_err++;
            $display("FAIL %s: got wr_ready=%b rd_ready=%b rd_valid=%b rd_data=%02h wr_ptr=%0d rd_ptr=%0d, required 1 1 0 00 0 0",
                     tag, wr_ready, rd_ready, rd_valid, rd_data, wr_ptr, rd_ptr);
        end
    endtask

    task automatic wait_wr_ready(input string tag);
        int waited = 0;
        while (wr_ready !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        n_vec++;
        if (wr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s wr_ready_timeout: got %b, required 1 within 20 cycles", tag, wr_ready);
        end
    endtask

    // Two-beat write burst; starts and ends on a falling edge.
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d0,
                            input logic [DATA_W-1:0] d1, input string tag);
        logic [ADDR_W-1:0] a1;
        a1 = a + 3'd1;
        wait_wr_ready(tag);
        wr_cmd  = 1'b1;
        wr_addr = a;
        wr_data = d0;
        step();
        wr_cmd  = 1'b0;
        wr_addr = $urandom;
        wr_data = d1;
        n_vec++;
        if (wr_ready !== 1'b0 || wr_ptr !== a1) begin
            n_err++;
            $display("FAIL %s mid_write: got wr_ready=%b wr_ptr=%0d, required 0 %0d", tag, wr_ready, wr_ptr, a1);
        end
        step();
        wr_data = $urandom;
        mem_m[a]  = d0;
        mem_m[a1] = d1;
        n_vec++;
        if (wr_ready !== 1'b1 || wr_ptr !== a1 + 3'd1) begin
            n_err++;
            $display("FAIL %s end_write: got wr_ready=%b wr_ptr=%0d, required 1 %0d",
                     tag, wr_ready, wr_ptr, a1 + 3'd1);
        end
    endtask

    // Two-beat read burst checked against the model, plus the idle cycle after it.
    task automatic do_read(input logic [ADDR_W-1:0] a, input string tag);
        logic [ADDR_W-1:0] ba;
        rd_cmd  = 1'b1;
        rd_addr = a;
        for (int k = 0; k < BURST_LEN; k++) begin
            step();
            rd_cmd  = 1'b0;
            rd_addr = $urandom;
            ba = a + ADDR_W'(k);
            n_vec++;
            if (rd_valid !== 1'b1 || rd_data !== mem_m[ba]) begin
                n_err++;
                $display("FAIL %s beat%0d addr%0d: got valid=%b data=%02h, required 1 %02h",
                         tag, k, ba, rd_valid, rd_data, mem_m[ba]);
            end
        end
        n_vec++;
        if (rd_ptr !== a + ADDR_W'(BURST_LEN) || rd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s rd_ptr: got ptr=%0d ready=%b, required %0d 1",
                     tag, rd_ptr, rd_ready, a + ADDR_W'(BURST_LEN));
        end
        step();
        n_vec++;
        if (rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s valid_len: got rd_valid=%b after burst, required 0", tag, rd_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        wr_cmd = 1'b0; wr_addr = '0; wr_data = '0;
        rd_cmd = 1'b0; rd_addr = '0;
        #2 rst = 1'b1;
        #1 check_idle_outputs("reset_por");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("reset_release");
    endtask

    task automatic test_preload();
        for (int a = 0; a < DEPTH; a += 2) begin
            do_write(ADDR_W'(a), DATA_W'($urandom), DATA_W'($urandom), "preload");
        end
    endtask

    task automatic test_basic();
        do_write(3'd3, 8'hA5, 8'h5A, "basic_wr");
        do_read(3'd3, "basic_rd");
    endtask

    task automatic test_wrap();
        do_write(3'd7, 8'h11, 8'h22, "wrap_wr");
        do_read(3'd7, "wrap_rd");
    endtask

    task automatic test_stream();
        rd_cmd = 1'b1;
        for (int i = 0; i < 3 * BURST_LEN; i++) begin
            n_vec++;
            if (rd_ready !== ((i % 2) == 0)) begin
                n_err++;
                $display("FAIL stream_ready%0d: got %b, required %b", i, rd_ready, (i % 2) == 0);
            end
            if ((i % 2) == 0) rd_addr = ADDR_W'(i);
            step();
            n_vec++;
            if (rd_valid !== 1'b1 || rd_data !== mem_m[i]) begin
                n_err++;
                $display("FAIL stream_beat%0d: got valid=%b data=%02h, required 1 %02h",
                         i, rd_valid, rd_data, mem_m[i]);
            end
        end
        rd_cmd = 1'b0;
        step();
        n_vec++;
        if (rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stream_end: got rd_valid=%b, required 0", rd_valid);
        end
    endtask

    // Write and read commands accepted on the same edge; each beat is resolved in time order.
    task automatic run_concurrent(input logic [ADDR_W-1:0] wa, input logic [ADDR_W-1:0] ra,
                                  input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                                  input string tag);
        logic [DATA_W-1:0] wd [BURST_LEN];
        logic [DATA_W-1:0] exp_v;
        logic [ADDR_W-1:0] wk, rk;
        wd[0] = d0;
        wd[1] = d1;
        wr_cmd = 1'b1; wr_addr = wa; wr_data = wd[0];
        rd_cmd = 1'b1; rd_addr = ra;
        for (int k = 0; k < BURST_LEN; k++) begin
            wk = wa + ADDR_W'(k);
            rk = ra + ADDR_W'(k);
            exp_v = mem_m[rk];
`ifdef RD_BYPASS_EN
            if (wk == rk) exp_v = wd[k];
`endif
            mem_m[wk] = wd[k];
            step();
            wr_cmd = 1'b0; rd_cmd = 1'b0;
            wr_addr = $urandom; rd_addr = $urandom;
            if (k + 1 < BURST_LEN) wr_data = wd[k+1];
            n_vec++;
            if (rd_valid !== 1'b1 || rd_data !== exp_v) begin
                n_err++;
                $display("FAIL %s beat%0d w%0d r%0d: got valid=%b data=%02h, required 1 %02h",
                         tag, k, wk, rk, rd_valid, rd_data, exp_v);
            end
        end
        step();
    endtask

    task automatic test_collision();
        do_write(3'd2, 8'h10, DATA_W'($urandom), "coll_pre");
        run_concurrent(3'd2, 3'd2, 8'h99, DATA_W'($urandom), "collision");
        do_read(3'd2, "coll_after");
    endtask

    task automatic test_reset_mid_read();
        rd_cmd = 1'b1;
        rd_addr = $urandom;
        step();
        rd_cmd = 1'b0;
        n_vec++;
        if (rd_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rst_read_pre: got rd_valid=%b, required 1", rd_valid);
        end
        #2 rst = 1'b1;
        #1 check_idle_outputs("rst_read_async");
        step();
        rst = 1'b0;
        step();
        n_vec++;
        if (rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_read_after: got rd_valid=%b, required 0", rd_valid);
        end
    endtask

    task automatic test_reset_mid_write();
        wr_cmd = 1'b1; wr_addr = 3'd4; wr_data = 8'h33;
        step();
        wr_cmd = 1'b0; wr_data = 8'hEE;
        mem_m[4] = 8'h33;
        #2 rst = 1'b1;
        #1 check_idle_outputs("rst_write_async");
        step();
        rst = 1'b0;
        n_vec++;
        if (wr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_write_ready: got %b, required 1", wr_ready);
        end
        do_read(3'd4, "rst_write_rd");
        do_write(3'd6, DATA_W'($urandom), DATA_W'($urandom), "rst_write_new");
        do_read(3'd6, "rst_write_new_rd");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(2))
                0: do_write(ADDR_W'($urandom), DATA_W'($urandom), DATA_W'($urandom), "rand_wr");
                1: do_read(ADDR_W'($urandom), "rand_rd");
                default: run_concurrent(ADDR_W'($urandom), ADDR_W'($urandom),
                                        DATA_W'($urandom), DATA_W'($urandom), "rand_conc");
            endcase
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_preload();
        test_basic();
        test_wrap();
        test_stream();
        test_collision();
        test_reset_mid_read();
        test_reset_mid_write();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
